temp_avg_alarm: RTL and testbench
=================================

# temp_avg_alarm

Downstream of the pulse-duration temperature converter: accepts one signed 9-bit °C sample per `temp_valid` strobe and keeps a sliding-window moving average over the last 2^AVG_LOG2 samples. It presents the average on a valid/ready output port and drives hot/cold alarm flags with hysteresis. It is the filtering and supervision stage between raw sensor conversion and the readout/control logic.

## Interface
- AVG_LOG2, 3, log2 of window length N (1..6)
- HOT_SET, 85, avg ≥ this raises alarm_hot
- HOT_CLR, 80, avg ≤ this clears alarm_hot
- COLD_SET, -30, avg ≤ this raises alarm_cold
- COLD_CLR, -25, avg ≥ this clears alarm_cold
- Parameter constraint: COLD_SET < COLD_CLR < HOT_CLR < HOT_SET
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- temp_in  in  9  signed sample, °C, range -256..255
- temp_valid  in  1  one-cycle strobe, temp_in valid; may be high every cycle
- avg_temp  out  9  signed window average, registered
- out_valid  out  1  avg_temp holds an unconsumed new average
- out_ready  in  1  consumer accepts avg_temp when out_valid & out_ready
- alarm_hot  out  1  registered hot alarm
- alarm_cold  out  1  registered cold alarm
- overrun  out  1  sticky: an unconsumed average was overwritten
- clr_overrun  in  1  clears overrun

## Operation
- Storage: N-entry circular buffer of 9-bit samples, write pointer wr_ptr (AVG_LOG2 bits, wraps N-1→0), fill counter 0..N, signed running sum of 9+AVG_LOG2 bits. This width cannot overflow.
- Accepted sample (temp_valid=1): new_sum = sum + temp_in − buf[wr_ptr]. Write buf[wr_ptr] = temp_in and increment wr_ptr. Increment the fill counter, saturating at N.
- Average: avg = new_sum >>> AVG_LOG2. This is an arithmetic shift, so it floors toward −∞. The result always fits in 9 bits.
- FSM states: FILL, NORMAL, HOT, COLD. Reset enters FILL.
- FILL: no average is published and alarms stay 0. On the sample that makes the fill counter equal N, evaluate the thresholds on the new avg and enter HOT, COLD or NORMAL accordingly. out_valid rises on that sample.
- NORMAL: go to HOT if avg ≥ HOT_SET, else to COLD if avg ≤ COLD_SET, else stay.
- HOT: go to COLD if avg ≤ COLD_SET. Go to NORMAL if avg ≤ HOT_CLR. Otherwise stay.
- COLD: go to HOT if avg ≥ HOT_SET. Go to NORMAL if avg ≥ COLD_CLR. Otherwise stay.
- The FSM is evaluated only on accepted samples once the window is full.
- alarm_hot = (state == HOT) and alarm_cold = (state == COLD). Both are registered and never high together.
- Output handshake:
  - A new avg loads avg_temp and sets out_valid.
  - When out_valid & out_ready, out_valid clears unless a new avg loads at the same edge; in that case out_valid stays 1 with the new value.
  - avg_temp holds stable while out_valid=1 and no new sample arrives.
- Overrun:
  - overrun sets when a new avg loads while out_valid=1 and out_ready=0.
  - clr_overrun clears it. If set and clear occur in the same cycle, set wins.
- Reset (any time, including mid-fill or mid-alarm) has the following values:
  - sum, buffer, wr_ptr and fill counter = 0.
  - state = FILL.
  - avg_temp=0, out_valid=0, alarm_hot=0, alarm_cold=0, overrun=0.
  - The window is flushed, so N fresh samples are required before the next output.

## Timing
- Latency: a sample strobed in cycle k updates sum, buffer, avg_temp, out_valid, the alarm flags and overrun at the rising edge ending cycle k. All are visible in cycle k+1.
- Throughput: one sample per cycle, with no stall on the input side. out_ready never back-pressures temp_valid.
- out_valid and out_ready are sampled at the same edge as temp_valid. Handshake completion and a new load in the same cycle follow the rules under Operation.
- Reset is synchronous: outputs reach their reset values at the first edge with reset_n=0.

## Test plan
- Reset, then seven samples of 25 → out_valid stays 0. The eighth sample → next cycle avg_temp=25, out_valid=1, both alarms 0.
- Fill with seven −3 and one −4 (sum −25) → avg_temp = −4 (floor).
- Fill with 90 → alarm_hot=1 after the 8th sample. Eight samples of 82 → alarm_hot stays 1. Eight samples of 79 → alarm_hot=0 once avg ≤ 80 (avg=80 clears it). Then eight samples of −40 → alarm_cold=1 and alarm_hot=0.
- Hold out_ready=0 after fill, with window=20 and avg=20. Strobe 28 → avg_temp=21, out_valid=1, overrun=1. Set out_ready=1 for one cycle → out_valid=0. Pulse clr_overrun → overrun=0.
- Full-scale extremes: eight samples of −256 → avg_temp=−256. Eight samples of 255 → avg_temp=255. wr_ptr wraps with no sum overflow. Back-to-back strobes every cycle give a new avg each cycle.
- After fill, assert reset_n=0 for one cycle → all outputs 0. Seven more samples → out_valid stays 0. The eighth → out_valid=1 with the average of those eight only.

Source files
------------

// File: rtl/temp_avg_alarm.sv
// temp_avg_alarm
// Sliding-window moving average of signed 9-bit temperature samples, with
// hot/cold alarm hysteresis and a valid/ready output port.
//
// Ports:
//   clk          clock
//   reset_n      synchronous, active-low reset
//   temp_in      signed sample, degrees C
//   temp_valid   one-cycle strobe qualifying temp_in
//   avg_temp     registered window average (floor)
//   out_valid    avg_temp holds an unconsumed new average
//   out_ready    consumer accepts avg_temp when out_valid & out_ready
//   alarm_hot    hot alarm (state HOT)
//   alarm_cold   cold alarm (state COLD)
//   overrun      sticky: an unconsumed average was overwritten
//   clr_overrun  clears overrun (a simultaneous set wins)
//
// state  | meaning
// FILL   | window not yet full, nothing published, alarms off
// NORMAL | window full, temperature within limits
// HOT    | hot alarm active until avg <= HOT_CLR
// COLD   | cold alarm active until avg >= COLD_CLR

module temp_avg_alarm #(
  parameter int AVG_LOG2 = 3,
  parameter int HOT_SET  = 85,
  parameter int HOT_CLR  = 80,
  parameter int COLD_SET = -30,
  parameter int COLD_CLR = -25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [8:0] temp_in,
  input  logic              temp_valid,
  output logic signed [8:0] avg_temp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              alarm_hot,
  output logic              alarm_cold,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 9 + AVG_LOG2;

  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(N - 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(N);

  localparam logic signed [8:0] HOT_SET_V  = 9'(HOT_SET);
  localparam logic signed [8:0] HOT_CLR_V  = 9'(HOT_CLR);
  localparam logic signed [8:0] COLD_SET_V = 9'(COLD_SET);
  localparam logic signed [8:0] COLD_CLR_V = 9'(COLD_CLR);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_NORMAL,
    ST_HOT,
    ST_COLD
  } state_t;

  state_t state, state_next;

  logic signed [8:0]    samples [N];
  logic [AVG_LOG2-1:0]  wr_ptr;
  logic [AVG_LOG2:0]    fill_cnt;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] new_sum;
  logic signed [8:0]    avg;
  logic                 load;

  // Unwritten slots hold 0 during fill, so the same subtract works from reset.
  always_comb begin
    new_sum = sum + SW'(temp_in) - SW'(samples[wr_ptr]);
    avg     = 9'(new_sum >>> AVG_LOG2);
  end

  // A new average is published on every accepted sample once the window is
  // full, including the sample that completes the first fill.
  always_comb begin
    load = temp_valid && ((state != ST_FILL) || (fill_cnt == FILL_LAST));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_FILL;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load) begin
      unique case (state)
        ST_FILL, ST_NORMAL: begin
          if (avg >= HOT_SET_V)       state_next = ST_HOT;
          else if (avg <= COLD_SET_V) state_next = ST_COLD;
          else                        state_next = ST_NORMAL;
        end
        ST_HOT: begin
          if (avg <= COLD_SET_V)     state_next = ST_COLD;
          else if (avg <= HOT_CLR_V) state_next = ST_NORMAL;
        end
        ST_COLD: begin
          if (avg >= HOT_SET_V)       state_next = ST_HOT;
          else if (avg >= COLD_CLR_V) state_next = ST_NORMAL;
        end
        default: state_next = ST_FILL;
      endcase
    end
  end

  assign alarm_hot  = (state == ST_HOT);
  assign alarm_cold = (state == ST_COLD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) samples[i] <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sum      <= '0;
    end else if (temp_valid) begin
      samples[wr_ptr] <= temp_in;
      wr_ptr          <= wr_ptr + AVG_LOG2'(1);
      sum             <= new_sum;
      if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + (AVG_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avg_temp  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        avg_temp  <= avg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_temp_avg_alarm.sv
// Testbench for temp_avg_alarm: directed scenarios plus a randomized run,
// all checked against a window/threshold reference model.
module tb_temp_avg_alarm;

  localparam int N        = 8;
  localparam int HOT_SET  = 85;
  localparam int HOT_CLR  = 80;
  localparam int COLD_SET = -30;
  localparam int COLD_CLR = -25;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic signed [8:0] temp_in = '0;
  logic              temp_valid = 1'b0;
  logic signed [8:0] avg_temp;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              alarm_hot;
  logic              alarm_cold;
  logic              overrun;
  logic              clr_overrun = 1'b0;

  int total = 0;
  int bad   = 0;

  // reference model state
  int                win[$];
  logic signed [8:0] m_avg;
  logic              m_valid, m_hot, m_cold, m_ovr;

  temp_avg_alarm #(
    .AVG_LOG2(3), .HOT_SET(HOT_SET), .HOT_CLR(HOT_CLR),
    .COLD_SET(COLD_SET), .COLD_CLR(COLD_CLR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .temp_in(temp_in), .temp_valid(temp_valid),
    .avg_temp(avg_temp), .out_valid(out_valid), .out_ready(out_ready),
    .alarm_hot(alarm_hot), .alarm_cold(alarm_cold), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, and
  // return 1 ns after the edge so outputs can be compared.
  task automatic cycle(input bit tv, input int t, input bit rdy, input bit clr, input bit rst_n);
    bit load;
    int s, a;
    temp_valid  = tv;
    temp_in     = 9'(t);
    out_ready   = rdy;
    clr_overrun = clr;
    reset_n     = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      win.delete();
      m_avg = '0; m_valid = 0; m_hot = 0; m_cold = 0; m_ovr = 0;
    end else begin
      load = 0;
      a = 0;
      if (tv) begin
        win.push_back(t);
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          s = 0;
          foreach (win[i]) s += win[i];
          a = floor_div(s);
          load = 1;
        end
      end
      if (load) begin
        if (m_hot) begin
          if (a <= COLD_SET) begin m_hot = 0; m_cold = 1; end
          else if (a <= HOT_CLR) m_hot = 0;
        end else if (m_cold) begin
          if (a >= HOT_SET) begin m_cold = 0; m_hot = 1; end
          else if (a >= COLD_CLR) m_cold = 0;
        end else begin
          if (a >= HOT_SET) m_hot = 1;
          else if (a <= COLD_SET) m_cold = 1;
        end
      end
      if (load && m_valid && !rdy) m_ovr = 1;
      else if (clr) m_ovr = 0;
      if (load) begin
        m_avg = 9'(a);
        m_valid = 1;
      end else if (rdy) m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    total++;
    if ({avg_temp, out_valid, alarm_hot, alarm_cold, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL reset: got avg=%0d v=%0b h=%0b c=%0b o=%0b, want all 0",
               avg_temp, out_valid, alarm_hot, alarm_cold, overrun);
    end
  endtask

  task automatic test_fill_avg();
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(1, 25, 1, 0, 1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL fill_valid_low[%0d]: got out_valid=%0b want 0", i, out_valid);
      end
    end
    cycle(1, 25, 1, 0, 1);
    total++;
    if ({avg_temp, out_valid, alarm_hot, alarm_cold} !== {9'sd25, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fill_first_avg: got avg=%0d v=%0b h=%0b c=%0b want 25 1 0 0",
               avg_temp, out_valid, alarm_hot, alarm_cold);
    end
  endtask

  task automatic test_floor();
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, -3, 1, 0, 1);
    cycle(1, -4, 1, 0, 1);
    total++;
    if (avg_temp !== -9'sd4 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL floor_avg: got avg=%0d v=%0b want -4 1", avg_temp, out_valid);
    end
  endtask

  task automatic test_hysteresis();
    int vals[4] = '{90, 82, 79, -40};
    cycle(0, 0, 1, 0, 0);
    foreach (vals[k]) begin
      for (int i = 0; i < 8; i++) begin
        cycle(1, vals[k], 1, 0, 1);
        total++;
        if ({avg_temp, out_valid, alarm_hot, alarm_cold} !== {m_avg, m_valid, m_hot, m_cold}) begin
          bad++;
          $display("FAIL hyst[%0d,%0d]: got avg=%0d v=%0b h=%0b c=%0b want %0d %0b %0b %0b",
                   vals[k], i, avg_temp, out_valid, alarm_hot, alarm_cold,
                   m_avg, m_valid, m_hot, m_cold);
        end
      end
      total++;
      if ((k <= 1 && {alarm_hot, alarm_cold} !== 2'b10) ||
          (k == 2 && {alarm_hot, alarm_cold} !== 2'b00) ||
          (k == 3 && {alarm_hot, alarm_cold} !== 2'b01)) begin
        bad++;
        $display("FAIL hyst_end[%0d]: got h=%0b c=%0b", vals[k], alarm_hot, alarm_cold);
      end
    end
  endtask

  task automatic test_overrun();
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 20, 0, 0, 1);
    cycle(1, 28, 0, 0, 1);
    total++;
    if ({avg_temp, out_valid, overrun} !== {9'sd21, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL overrun_set: got avg=%0d v=%0b o=%0b want 21 1 1",
               avg_temp, out_valid, overrun);
    end
    cycle(0, 0, 1, 0, 1);
    total++;
    if ({avg_temp, out_valid, overrun} !== {9'sd21, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL overrun_consume: got avg=%0d v=%0b o=%0b want 21 0 1",
               avg_temp, out_valid, overrun);
    end
    cycle(0, 0, 0, 1, 1);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got o=%0b want 0", overrun);
    end
    // load into a full register with clear asserted: set must win
    cycle(1, 20, 0, 0, 1);
    cycle(1, 20, 0, 1, 1);
    total++;
    if ({out_valid, overrun} !== 2'b11 || {out_valid, overrun} !== {m_valid, m_ovr}) begin
      bad++;
      $display("FAIL overrun_set_wins: got v=%0b o=%0b want 1 1", out_valid, overrun);
    end
    // consume and load in the same edge keeps out_valid high, no overrun
    cycle(0, 0, 0, 1, 1);
    cycle(1, 36, 1, 0, 1);
    total++;
    if ({avg_temp, out_valid, overrun} !== {m_avg, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL consume_and_load: got avg=%0d v=%0b o=%0b want %0d 1 0",
               avg_temp, out_valid, overrun, m_avg);
    end
  endtask

  task automatic test_extremes();
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, -256, 1, 0, 1);
    total++;
    if (avg_temp !== -9'sd256 || alarm_cold !== 1'b1) begin
      bad++;
      $display("FAIL extreme_low: got avg=%0d c=%0b want -256 1", avg_temp, alarm_cold);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1, 255, 1, 0, 1);
      total++;
      if ({avg_temp, out_valid, alarm_hot, alarm_cold} !== {m_avg, 1'b1, m_hot, m_cold}) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got avg=%0d v=%0b h=%0b c=%0b want %0d 1 %0b %0b",
                 i, avg_temp, out_valid, alarm_hot, alarm_cold, m_avg, m_hot, m_cold);
      end
    end
    total++;
    if (avg_temp !== 9'sd255) begin
      bad++;
      $display("FAIL extreme_high: got avg=%0d want 255", avg_temp);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 90, 0, 0, 1);
    cycle(1, 100, 0, 0, 0);
    total++;
    if ({avg_temp, out_valid, alarm_hot, alarm_cold, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL mid_reset: got avg=%0d v=%0b h=%0b c=%0b o=%0b want all 0",
               avg_temp, out_valid, alarm_hot, alarm_cold, overrun);
    end
    for (int i = 0; i < 7; i++) cycle(1, 10 + i, 1, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_refill: got v=%0b want 0", out_valid);
    end
    cycle(1, 17, 1, 0, 1);
    total++;
    if ({avg_temp, out_valid, alarm_hot} !== {9'sd13, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_avg: got avg=%0d v=%0b h=%0b want 13 1 0",
               avg_temp, out_valid, alarm_hot);
    end
  endtask

  task automatic test_random();
    int bases[5] = '{-40, -28, 0, 82, 95};
    int base = 0;
    int t;
    bit tv, rdy, clr, rst;
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) base = bases[$urandom_range(0, 4)];
      t   = base + int'($urandom_range(0, 24)) - 12;
      tv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) != 0);
      cycle(tv, t, rdy, clr, rst);
      total++;
      if ({avg_temp, out_valid, alarm_hot, alarm_cold, overrun} !==
          {m_avg, m_valid, m_hot, m_cold, m_ovr}) begin
        bad++;
        $display("FAIL random[%0d]: got avg=%0d v=%0b h=%0b c=%0b o=%0b want %0d %0b %0b %0b %0b",
                 i, avg_temp, out_valid, alarm_hot, alarm_cold, overrun,
                 m_avg, m_valid, m_hot, m_cold, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_avg();
    test_floor();
    test_hysteresis();
    test_overrun();
    test_extremes();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
